// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared PS/2 definitions used by the host transmitter and receive-side logic.
//   - ps2_state_e     : host-to-device transmit state encoding
//   - PS2_*_CYCLES    : default timing constants at 100 MHz
//   - ps2_odd_parity  : parity bit that makes the 9-bit {parity, byte} odd
// -----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_state_e;

    localparam int PS2_INHIBIT_CYCLES = 10000;    // 100 us
    localparam int PS2_RTS_CYCLES     = 2000;     // 20 us
    localparam int PS2_TIMEOUT_CYCLES = 1500000;  // 15 ms
    localparam int PS2_FILTER_CYCLES  = 8;

    // Odd parity: 1 when the byte holds an even number of ones.
    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// -----------------------------------------------------------------------------
// ps2_line_filter
// Brings one PS/2 pad into the clk domain and debounces it.
//   clk      in  system clock
//   rst      in  asynchronous active-low reset (line assumed idle-high)
//   i_line   in  raw pad level
//   o_level  out filtered level, changes after FILTER_CYCLES identical samples
//   o_fall   out one-cycle strobe when o_level goes 1 -> 0
// -----------------------------------------------------------------------------
module ps2_line_filter #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    // r_cnt counts consecutive synchronized samples that disagree with the
    // current filtered level; any agreeing sample restarts the run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_line;
            r_sync2 <= r_sync1;
            r_fall  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_CYCLES - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_fall  <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device command transmitter (open-collector line control).
//   clk, rst             system clock; asynchronous active-low reset
//   tx_data/valid/ready  command byte handshake (ready only in IDLE)
//   ps2_clk_in/data_in   sampled pad levels
//   ps2_clk_oe/data_oe   1 = pull the line low, 0 = release
//   busy                 frame in progress
//   done, ack_ok         completion pulse and device ACK result
//   error                pulse when the device fails to finish in time
// -----------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int RTS_CYCLES     = PS2_RTS_CYCLES,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
    parameter int FILTER_CYCLES  = PS2_FILTER_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error
);

    localparam int PH_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_e      r_state,   w_state_nxt;
    logic [PH_W-1:0] r_ph,      w_ph_nxt;
    logic [TO_W-1:0] r_tmo,     w_tmo_nxt;
    logic [3:0]      r_bit,     w_bit_nxt;
    logic [7:0]      r_byte,    w_byte_nxt;
    logic            r_data_oe, w_data_oe_nxt;
    logic            r_ack,     w_ack_nxt;
    logic            w_timeout;

    logic w_clk_lvl;
    logic w_clk_fall;
    logic w_data_lvl;
    logic w_data_fall_unused;  // transmit side only needs the data level

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_flt (
        .clk     (clk),
        .rst     (rst),
        .i_line  (ps2_clk_in),
        .o_level (w_clk_lvl),
        .o_fall  (w_clk_fall)
    );

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_flt (
        .clk     (clk),
        .rst     (rst),
        .i_line  (ps2_data_in),
        .o_level (w_data_lvl),
        .o_fall  (w_data_fall_unused)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_ph      <= '0;
            r_tmo     <= '0;
            r_bit     <= '0;
            r_byte    <= '0;
            r_data_oe <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ph      <= w_ph_nxt;
            r_tmo     <= w_tmo_nxt;
            r_bit     <= w_bit_nxt;
            r_byte    <= w_byte_nxt;
            r_data_oe <= w_data_oe_nxt;
            r_ack     <= w_ack_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ph_nxt      = r_ph;
        w_tmo_nxt     = r_tmo;
        w_bit_nxt     = r_bit;
        w_byte_nxt    = r_byte;
        w_data_oe_nxt = r_data_oe;
        w_ack_nxt     = r_ack;
        w_timeout     = 1'b0;
        done          = 1'b0;
        error         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (tx_valid && tx_ready) begin
                    w_byte_nxt  = tx_data;
                    w_ph_nxt    = '0;
                    w_state_nxt = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (r_ph == PH_W'(INHIBIT_CYCLES - 1)) begin
                    w_ph_nxt    = '0;
                    w_state_nxt = ST_RTS;
                end else begin
                    w_ph_nxt = r_ph + 1'b1;
                end
            end
            ST_RTS: begin
                if (r_ph == PH_W'(RTS_CYCLES - 1)) begin
                    w_ph_nxt      = '0;
                    w_tmo_nxt     = '0;
                    w_bit_nxt     = '0;
                    w_data_oe_nxt = 1'b1;  // keep the start bit through clock release
                    w_state_nxt   = ST_SEND;
                end else begin
                    w_ph_nxt = r_ph + 1'b1;
                end
            end
            ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
                // Timeout has priority so done and error can never coincide.
                if (r_tmo == TO_W'(TIMEOUT_CYCLES)) begin
                    w_timeout     = 1'b1;
                    error         = 1'b1;
                    w_data_oe_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                    if (r_state == ST_SEND) begin
                        if (w_clk_fall) begin
                            w_bit_nxt = r_bit + 1'b1;
                            if (r_bit < 4'd8) begin
                                w_data_oe_nxt = ~r_byte[r_bit[2:0]];
                            end else if (r_bit == 4'd8) begin
                                w_data_oe_nxt = ~ps2_odd_parity(r_byte);
                            end else begin
                                w_data_oe_nxt = 1'b0;  // stop bit: release
                                w_state_nxt   = ST_ACK;
                            end
                        end
                    end else if (r_state == ST_ACK) begin
                        if (w_clk_fall) begin
                            w_ack_nxt   = ~w_data_lvl;
                            w_state_nxt = ST_WAIT_IDLE;
                        end
                    end else begin
                        if (w_clk_lvl && w_data_lvl) begin
                            done        = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // tx_ready is held low while reset is asserted so nothing is accepted then.
    assign tx_ready    = (r_state == ST_IDLE) && rst;
    assign busy        = (r_state != ST_IDLE);
    assign ps2_clk_oe  = (r_state == ST_INHIBIT) || (r_state == ST_RTS);
    assign ps2_data_oe = (r_state == ST_RTS) ||
                         ((r_state == ST_SEND) && r_data_oe && !w_timeout);
    assign ack_ok      = done && r_ack;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int RTS = 12;
    localparam int TMO = 2000;
    localparam int FLT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, done, ack_ok, error;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    // Open-collector bus: a line is low if either side pulls it.
    assign ps2_clk_in  = !(ps2_clk_oe || dev_clk_low);
    assign ps2_data_in = !(ps2_data_oe || dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .RTS_CYCLES     (RTS),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_CYCLES  (FLT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .ack_ok      (ack_ok),
        .error       (error)
    );

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (done && error) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshake one byte and measure the inhibit / request-to-send phases.
    task automatic request(input logic [7:0] b, input logic inject);
        int guard;
        int inh;
        int rts;
        guard = 0;
        while (!tx_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_req", 32'(tx_ready), 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        if (inject) tx_data = 8'hAA;
        else        tx_valid = 1'b0;
        inh = 0;
        while (ps2_clk_oe && !ps2_data_oe && inh < INH + 100) begin
            inh++;
            @(negedge clk);
        end
        rts = 0;
        while (ps2_clk_oe && ps2_data_oe && rts < RTS + 100) begin
            rts++;
            @(negedge clk);
        end
        chk("inhibit_len", 32'(inh), 32'(INH));
        chk("rts_len", 32'(rts), 32'(RTS));
        chk("send_clk_released", 32'(ps2_clk_oe), 32'd0);
        chk("start_bit_held", 32'(ps2_data_oe), 32'd1);
    endtask

    // Device model: 11 clock pulses, reads bits at the end of each low phase,
    // optionally pulls data low as ACK; reference: {stop=1, odd parity, byte}.
    task automatic run_frame(input logic [7:0] b, input logic ack_low, input int half,
                             input int abort_after, input logic inject);
        int         d0;
        int         e0;
        int         guard;
        logic [9:0] seen;
        logic [9:0] exp_bits;
        logic       ackv;
        logic       got;
        d0       = done_cnt;
        e0       = err_cnt;
        seen     = '0;
        ackv     = 1'bx;
        got      = 1'b0;
        exp_bits = {1'b1, ~^b, b};
        request(b, inject);
        for (int i = 1; i <= 11; i++) begin
            if (i == 11) dev_data_low = ack_low;
            repeat (half) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (half) @(negedge clk);
            if (i == abort_after) begin
                rst = 1'b0;
                #1;
                chk("abort_clk_oe", 32'(ps2_clk_oe), 32'd0);
                chk("abort_data_oe", 32'(ps2_data_oe), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done_err", 32'({done, error}), 32'd0);
                dev_clk_low  = 1'b0;
                dev_data_low = 1'b0;
                tx_valid     = 1'b0;
                repeat (3) @(negedge clk);
                rst = 1'b1;
                repeat (30) @(negedge clk);
                chk("abort_no_done", 32'(done_cnt), 32'(d0));
                chk("abort_no_error", 32'(err_cnt), 32'(e0));
                chk("ready_after_abort", 32'(tx_ready), 32'd1);
                return;
            end
            if (i <= 10) seen[i-1] = ~(ps2_data_oe | dev_data_low);
            dev_clk_low = 1'b0;
        end
        if (inject) tx_valid = 1'b0;
        dev_data_low = 1'b0;
        guard = 0;
        while (!got && guard < 200) begin
            @(negedge clk);
            guard++;
            if (done) begin
                got  = 1'b1;
                ackv = ack_ok;
                chk("error_with_done", 32'(error), 32'd0);
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("ack_ok", 32'(ackv), 32'(ack_low));
        @(negedge clk);
        chk("ready_after_done", 32'(tx_ready), 32'd1);
        chk("frame_bits", 32'(seen), 32'(exp_bits));
        repeat (40) @(negedge clk);
        chk("single_done", 32'(done_cnt), 32'(d0 + 1));
        chk("no_error", 32'(err_cnt), 32'(e0));
        chk("idle_after_frame", 32'(busy), 32'd0);
    endtask

    // Device never clocks: error must appear TMO cycles after SEND entry.
    task automatic timeout_frame(input logic [7:0] b);
        int d0;
        int e0;
        int t;
        d0 = done_cnt;
        e0 = err_cnt;
        request(b, 1'b0);
        t = 0;
        while (!error && t < TMO + 100) begin
            @(negedge clk);
            t++;
        end
        chk("timeout_latency", 32'(t), 32'(TMO));
        chk("timeout_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        chk("timeout_no_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("ready_after_timeout", 32'(tx_ready), 32'd1);
        repeat (5) @(negedge clk);
        chk("timeout_err_count", 32'(err_cnt), 32'(e0 + 1));
        chk("timeout_done_count", 32'(done_cnt), 32'(d0));
    endtask

    initial begin
        logic [7:0] rb;
        logic       ra;
        int         rh;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        chk("reset_flags", 32'({busy, done, ack_ok, error}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(tx_ready), 32'd1);

        run_frame(8'hF4, 1'b1, 20, 0, 1'b0);
        run_frame(8'hFF, 1'b0, 20, 0, 1'b0);
        timeout_frame(8'h3C);
        run_frame(8'hA7, 1'b1, 20, 4, 1'b0);
        run_frame(8'h00, 1'b1, 20, 0, 1'b0);
        run_frame(8'h55, 1'b1, 20, 0, 1'b1);

        for (int k = 0; k < 6; k++) begin
            rb = 8'($urandom_range(0, 255));
            ra = 1'($urandom_range(0, 1));
            rh = int'($urandom_range(16, 30));
            run_frame(rb, ra, rh, 0, 1'b0);
        end

        chk("done_error_overlap", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000, clock-low inhibit length (100 us at 100 MHz).
REQ-002 Parameter RTS_CYCLES, default 2000, clock-low overlap after data pulled low (20 us).
REQ-003 Parameter TIMEOUT_CYCLES, default 1500000, max cycles from clock release to frame end (15 ms).
REQ-004 Parameter FILTER_CYCLES, default 8, stable-sample count for line filtering.
REQ-005 clk  in  1  system clock, 100 MHz, single clock domain.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 tx_data  in  8  command byte to device.
REQ-008 tx_valid  in  1  request; accepted when tx_valid && tx_ready.
REQ-009 tx_ready  out  1  high in IDLE only.
REQ-010 ps2_clk_in  in  1  sampled ps2_clk pad.
REQ-011 ps2_data_in  in  1  sampled ps2_data pad.
REQ-012 ps2_clk_oe  out  1  1 = drive ps2_clk low; 0 = release (open-collector).
REQ-013 ps2_data_oe  out  1  1 = drive ps2_data low; 0 = release.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse at frame completion.
REQ-016 ack_ok  out  1  device ACK result, valid while done=1.
REQ-017 error  out  1  one-cycle pulse on timeout.

Function
REQ-018 Inputs pass 2-FF synchronizer, then filter: filtered level changes only after FILTER_CYCLES identical samples.
REQ-019 Device-clock falling edge = filtered ps2_clk 1->0, one-cycle strobe.
REQ-020 States: IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE.
REQ-021 IDLE: both oe 0, tx_ready 1; on handshake latch tx_data, go INHIBIT next cycle.
REQ-022 INHIBIT: clk_oe 1, data_oe 0, exactly INHIBIT_CYCLES cycles, then RTS.
REQ-023 RTS: clk_oe 1, data_oe 1 (start bit), exactly RTS_CYCLES cycles, then SEND with clk_oe 0, data_oe 1.
REQ-024 SEND: bit counter 1..10 incremented on each falling edge; edges 1-8 drive data bits LSB first, edge 9 drives parity, edge 10 releases data (stop), then ACK.
REQ-025 Data drive rule: data_oe = NOT(bit); oe updates in the cycle after the edge strobe.
REQ-026 Parity is odd: parity bit = XNOR-reduction of latched byte.
REQ-027 ACK: on the 11th falling edge sample filtered data; ack_ok = NOT(sample); go WAIT_IDLE.
REQ-028 WAIT_IDLE: when filtered clk and data both 1, pulse done, return IDLE.
REQ-029 Timeout counter starts at SEND entry; reaching TIMEOUT_CYCLES in SEND/ACK/WAIT_IDLE: both oe 0, error pulse, no done, IDLE.
REQ-030 tx_valid while busy is ignored, no queuing; latched byte is stable for whole frame.
REQ-031 done and error never assert in the same cycle.

Reset
REQ-032 Asynchronous on rst=0: state IDLE, both oe 0 (lines released immediately), tx_ready 1 after release, busy/done/ack_ok/error 0, counters and filters cleared to 1-level (idle bus).
REQ-033 Reset mid-frame aborts without done or error.

Structure
REQ-034 Package ps2_pkg holds state enum and default timing constants, shared with receive-side PS/2 logic.
REQ-035 Sub-module ps2_line_filter (synchronizer, filter, falling-edge strobe), instantiated for clk and data.

Verification
REQ-036 tx_data=0xF4, device model clocks 80 us period, ACK low -> bits 0,0,1,0,1,1,1,1, parity 0, stop released; done=1, ack_ok=1, tx_ready=1 next cycle.
REQ-037 Any byte -> clk_oe high exactly 10000 cycles before data_oe rises; overlap exactly 2000 cycles; then clk_oe 0.
REQ-038 tx_data=0xFF, device leaves data high on 11th clock -> parity 1 sent, done=1, ack_ok=0, error=0.
REQ-039 Device never clocks -> error pulse exactly 1500000 cycles after SEND entry, both oe 0, tx_ready 1, no done.
REQ-040 rst=0 after 4th falling edge -> both oe 0 same cycle, no done/error; new request 0x00 afterwards sends parity 1 correctly.
REQ-041 tx_valid with 0xAA asserted during frame of 0x55 -> ignored; 0x55 bits and parity 1 on line, single done.
